// File: rtl/clk_div_prog.sv
// clk_div_prog -- programmable integer clock divider with a glitch-free
// configuration handshake.
//
// Optional feature: define CLK_DIV_PROG_DUTY_EN to take the high time from
// i_cfg_high. Without it the high time is always D>>1, and i_cfg_high is
// still present but ignored.
//
// Parameters
//   P_CNT_W        counter / divisor width (2..32)
//   P_DIV_DEFAULT  divisor after reset (values below 2 become 2)
// Ports
//   i_clk          clock, all logic on the rising edge
//   i_rst          synchronous reset, active low
//   i_en           divider run enable
//   i_cfg_valid    configuration offered (taken when o_cfg_ready=1)
//   i_cfg_div      requested divisor D
//   i_cfg_high     requested high time H in i_clk cycles
//   o_cfg_ready    no configuration pending; a new one can be accepted
//   o_clk_div      divided clock, registered
//   o_tick         one-cycle pulse with each o_clk_div rising edge
//   o_div_cur      divisor currently in effect

module clk_div_prog #(
    parameter int P_CNT_W       = 16,
    parameter int P_DIV_DEFAULT = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic               i_cfg_valid,
    input  logic [P_CNT_W-1:0] i_cfg_div,
    input  logic [P_CNT_W-1:0] i_cfg_high,
    output logic               o_cfg_ready,
    output logic               o_clk_div,
    output logic               o_tick,
    output logic [P_CNT_W-1:0] o_div_cur
);

    localparam int                 DIV_RST_I = (P_DIV_DEFAULT < 2) ? 2 : P_DIV_DEFAULT;
    localparam logic [P_CNT_W-1:0] DIV_RST   = P_CNT_W'(DIV_RST_I);
    localparam logic [P_CNT_W-1:0] ONE       = P_CNT_W'(1);
    localparam logic [P_CNT_W-1:0] TWO       = P_CNT_W'(2);

    typedef struct packed {
        logic [P_CNT_W-1:0] div;
        logic [P_CNT_W-1:0] high;
    } cfg_t;

    cfg_t               pend;      // accepted, waiting for a period boundary
    cfg_t               acc_cfg;   // clamped view of the offered configuration
    logic [P_CNT_W-1:0] high_cur;
    logic [P_CNT_W-1:0] cnt;
    logic               pend_vld;
    logic               wrap;

    // A pending configuration exists exactly when ready is low.
    assign pend_vld = ~o_cfg_ready;
    assign wrap     = (cnt == o_div_cur - ONE);

    always_comb begin
        acc_cfg.div = (i_cfg_div < TWO) ? TWO : i_cfg_div;
`ifdef CLK_DIV_PROG_DUTY_EN
        if (i_cfg_high == '0 || i_cfg_high >= acc_cfg.div)
            acc_cfg.high = acc_cfg.div >> 1;
        else
            acc_cfg.high = i_cfg_high;
`else
        acc_cfg.high = acc_cfg.div >> 1;
`endif
    end

`ifndef CLK_DIV_PROG_DUTY_EN
    // High time comes from D alone; keep the port but mark it as sink-only.
    logic unused_cfg_high;
    assign unused_cfg_high = ^i_cfg_high;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            cnt         <= '0;
            o_clk_div   <= 1'b0;
            o_tick      <= 1'b0;
            o_cfg_ready <= 1'b1;
            o_div_cur   <= DIV_RST;
            high_cur    <= DIV_RST >> 1;
            pend        <= '0;
        end else begin
            // Outputs reflect the counter value held before this edge, so the
            // first enabled edge (counter parked at 0) raises clk and tick together.
            if (i_en) begin
                o_clk_div <= (cnt < high_cur);
                o_tick    <= (cnt == '0);
                cnt       <= wrap ? '0 : cnt + ONE;
            end else begin
                o_clk_div <= 1'b0;
                o_tick    <= 1'b0;
                cnt       <= '0;
            end

            // Apply on a wrap (running) or immediately when stopped. The pending
            // flag is sampled pre-edge, so a config accepted on a wrap edge
            // waits for the following wrap.
            if (pend_vld && (!i_en || wrap)) begin
                o_div_cur   <= pend.div;
                high_cur    <= pend.high;
                o_cfg_ready <= 1'b1;
            end else if (i_cfg_valid && o_cfg_ready) begin
                pend        <= acc_cfg;
                o_cfg_ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
module tb_clk_div_prog;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        cfg_valid;
    logic [15:0] cfg_div;
    logic [15:0] cfg_high;
    logic        cfg_ready;
    logic        clk_div;
    logic        tick;
    logic [15:0] div_cur;

    typedef struct {
        logic        clk_div;
        logic        tick;
        logic        rdy;
        logic [15:0] div;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    clk_div_prog #(.P_CNT_W(16), .P_DIV_DEFAULT(4)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_cfg_valid (cfg_valid),
        .i_cfg_div   (cfg_div),
        .i_cfg_high  (cfg_high),
        .o_cfg_ready (cfg_ready),
        .o_clk_div   (clk_div),
        .o_tick      (tick),
        .o_div_cur   (div_cur)
    );

    // Monitor: every edge that has an outstanding expectation is checked.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_chk++;
                if (clk_div !== e.clk_div || tick !== e.tick ||
                    cfg_ready !== e.rdy || div_cur !== e.div) begin
                    n_err++;
                    $display("FAIL %s: got clk=%0b tick=%0b rdy=%0b div=%0d, expected clk=%0b tick=%0b rdy=%0b div=%0d",
                             e.tag, clk_div, tick, cfg_ready, div_cur,
                             e.clk_div, e.tick, e.rdy, e.div);
                end
            end
        end
    end

    // One cycle of stimulus; the expectation is for the outputs after the next edge.
    task automatic step(input logic r, input logic e_n, input logic cv,
                        input int d, input int h,
                        input logic ec, input logic et, input logic er,
                        input int ediv, input string tag);
        exp_t x;
        @(negedge clk);
        rst       = r;
        en        = e_n;
        cfg_valid = cv;
        cfg_div   = d[15:0];
        cfg_high  = h[15:0];
        x.clk_div = ec;
        x.tick    = et;
        x.rdy     = er;
        x.div     = ediv[15:0];
        x.tag     = tag;
        q.push_back(x);
    endtask

    // n running cycles; patterns are written first-cycle-leftmost.
    task automatic run(input int n, input logic [31:0] cb, input logic [31:0] tb_,
                       input logic er, input int ediv, input string tag);
        for (int k = 0; k < n; k++)
            step(1'b1, 1'b1, 1'b0, 0, 0, cb[n-1-k], tb_[n-1-k], er, ediv, tag);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0; cfg_high = '0;

        // reset state
        step(0, 0, 0, 0, 0, 0, 0, 1, 4, "reset0");
        step(0, 0, 0, 0, 0, 0, 0, 1, 4, "reset1");

        // default divisor 4: 1,1,0,0
        run(8, 32'b11001100, 32'b10001000, 1, 4, "default");

        // abort at counter=2, then a fresh period on re-enable
        run(2, 32'b11, 32'b10, 1, 4, "abort_pre");
        step(1, 0, 0, 0, 0, 0, 0, 1, 4, "abort");
        step(1, 0, 0, 0, 0, 0, 0, 1, 4, "abort_hold");
        step(1, 1, 0, 0, 0, 1, 1, 1, 4, "restart");
        step(1, 1, 0, 0, 0, 1, 0, 1, 4, "restart2");
        step(1, 0, 0, 0, 0, 0, 0, 1, 4, "stop");

        // odd divisor configured while disabled
        step(1, 0, 1, 5, 4, 0, 0, 0, 4, "odd_acc");
        step(1, 0, 0, 0, 0, 0, 0, 1, 5, "odd_apply");
`ifdef CLK_DIV_PROG_DUTY_EN
        run(10, 32'b1111011110, 32'b1000010000, 1, 5, "odd_duty");
`else
        run(10, 32'b1100011000, 32'b1000010000, 1, 5, "odd_half");
`endif
        step(1, 0, 0, 0, 0, 0, 0, 1, 5, "odd_stop");

        // clamping
        step(1, 0, 1, 0, 0, 0, 0, 0, 5, "d0_acc");
        step(1, 0, 0, 0, 0, 0, 0, 1, 2, "d0_apply");
        step(1, 0, 1, 1, 0, 0, 0, 0, 2, "d1_acc");
        step(1, 0, 0, 0, 0, 0, 0, 1, 2, "d1_apply");
        run(4, 32'b1010, 32'b1010, 1, 2, "div2");
        step(1, 0, 0, 0, 0, 0, 0, 1, 2, "div2_stop");
        step(1, 0, 1, 6, 9, 0, 0, 0, 2, "h9_acc");
        step(1, 0, 0, 0, 0, 0, 0, 1, 6, "h9_apply");
        run(6, 32'b111000, 32'b100000, 1, 6, "h9_run");
        step(1, 0, 0, 0, 0, 0, 0, 1, 6, "h9_stop");

        // mid-period reconfiguration: D=4 running, D=6 accepted at counter=1
        step(1, 0, 1, 4, 0, 0, 0, 0, 6, "d4_acc");
        step(1, 0, 0, 0, 0, 0, 0, 1, 4, "d4_apply");
        step(1, 1, 0, 0, 0, 1, 1, 1, 4, "rc_c0");
        step(1, 1, 1, 6, 3, 1, 0, 0, 4, "rc_acc");
        step(1, 1, 0, 0, 0, 0, 0, 0, 4, "rc_c2");
        step(1, 1, 0, 0, 0, 0, 0, 1, 6, "rc_apply");
        run(6, 32'b111000, 32'b100000, 1, 6, "rc_new");

        // boundary collision: D=8 accepted on the wrap cycle
        run(5, 32'b11100, 32'b10000, 1, 6, "col_pre");
        step(1, 1, 1, 8, 0, 0, 0, 0, 6, "col_acc");
        run(5, 32'b11100, 32'b10000, 0, 6, "col_old");
        step(1, 1, 0, 0, 0, 0, 0, 1, 8, "col_apply");
        run(9, 32'b111100001, 32'b100000001, 1, 8, "col_new");

        // reset discards a pending config and a handshake during reset
        step(1, 1, 1, 3, 0, 1, 0, 0, 8, "rp_acc");
        step(0, 1, 0, 0, 0, 0, 0, 1, 4, "rp_rst");
        step(0, 1, 1, 10, 0, 0, 0, 1, 4, "rp_rst_hs");
        step(1, 0, 0, 0, 0, 0, 0, 1, 4, "rp_noapply");
        run(4, 32'b1100, 32'b1000, 1, 4, "rp_default");

        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d expectations left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
